// File: rtl/mmio_interconnect.sv
// rtl/mmio_interconnect.sv - registered MMIO decoder/fabric between the CPU data port and NumSlaves peripherals
module mmio_interconnect #(
    parameter int                           NumSlaves     = 4,
    parameter int                           AddrWidth     = 32,
    parameter int                           DataWidth     = 32,
    parameter logic [NumSlaves*AddrWidth-1:0] SlaveBase   = '0,
    parameter logic [NumSlaves*AddrWidth-1:0] SlaveMask   = '0,
    parameter int                           TimeoutCycles = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [AddrWidth-1:0]           addr_i,
    input  logic [DataWidth-1:0]           wdata_i,
    input  logic                           wr_i,
    input  logic                           strobe_i,
    output logic [DataWidth-1:0]           rdata_o,
    output logic                           ready_o,
    output logic                           err_o,
    output logic [NumSlaves-1:0]           s_sel_o,
    output logic [AddrWidth-1:0]           s_addr_o,
    output logic [DataWidth-1:0]           s_wdata_o,
    output logic                           s_wr_o,
    input  logic [NumSlaves*DataWidth-1:0] s_rdata_i,
    input  logic [NumSlaves-1:0]           s_ready_i,
    output logic [7:0]                     err_count_o,
    output logic [AddrWidth-1:0]           last_err_addr_o
);

    localparam int CntW = $clog2(TimeoutCycles + 1);
    localparam int IdxW = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state;
    logic [IdxW-1:0]     idx;
    logic                miss_q;
    logic                wr_q;
    logic [CntW-1:0]     cnt;

    logic                hit;
    logic [IdxW-1:0]     hit_idx;
    logic                sel_ready;
    logic [DataWidth-1:0] sel_rdata;

    // Descending scan so the lowest-indexed overlapping window is the one kept.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NumSlaves - 1; i >= 0; i--) begin
            if ((addr_i & SlaveMask[i*AddrWidth +: AddrWidth]) == SlaveBase[i*AddrWidth +: AddrWidth]) begin
                hit     = 1'b1;
                hit_idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NumSlaves; i++) begin
            if (IdxW'(i) == idx) begin
                sel_ready = s_ready_i[i];
                sel_rdata = s_rdata_i[i*DataWidth +: DataWidth];
            end
        end
    end

    assign s_wr_o = wr_q & (|s_sel_o);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            idx             <= '0;
            miss_q          <= 1'b0;
            wr_q            <= 1'b0;
            cnt             <= '0;
            rdata_o         <= '0;
            ready_o         <= 1'b0;
            err_o           <= 1'b0;
            s_sel_o         <= '0;
            s_addr_o        <= '0;
            s_wdata_o       <= '0;
            err_count_o     <= '0;
            last_err_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (strobe_i) begin
                        s_addr_o  <= addr_i;
                        s_wdata_o <= wdata_i;
                        wr_q      <= wr_i;
                        cnt       <= '0;
                        idx       <= hit_idx;
                        miss_q    <= ~hit;
                        s_sel_o   <= hit ? (NumSlaves'(1) << hit_idx) : '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // An unmapped request spends this cycle with no slave selected, then errors.
                    if (!miss_q && sel_ready) begin
                        s_sel_o <= '0;
                        ready_o <= 1'b1;
                        err_o   <= 1'b0;
                        rdata_o <= wr_q ? '0 : sel_rdata;
                        state   <= RESP;
                    end else if (miss_q || cnt == CntW'(TimeoutCycles - 1)) begin
                        s_sel_o         <= '0;
                        ready_o         <= 1'b1;
                        err_o           <= 1'b1;
                        rdata_o         <= '0;
                        last_err_addr_o <= s_addr_o;
                        if (err_count_o != 8'hFF) begin
                            err_count_o <= err_count_o + 8'd1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                RESP: begin
                    ready_o <= 1'b0;
                    err_o   <= 1'b0;
                    rdata_o <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_interconnect.sv
// tb/tb_mmio_interconnect.sv - randomized self-checking bench for mmio_interconnect
module tb_mmio_interconnect;

    localparam int T = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        wr_i;
    logic        strobe_i;
    logic [31:0] rdata_o;
    logic        ready_o;
    logic        err_o;
    logic [1:0]  s_sel_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_wdata_o;
    logic        s_wr_o;
    logic [63:0] s_rdata_i;
    logic [1:0]  s_ready_i;
    logic [7:0]  err_count_o;
    logic [31:0] last_err_addr_o;

    mmio_interconnect #(
        .NumSlaves    (2),
        .AddrWidth    (32),
        .DataWidth    (32),
        .SlaveBase    ({32'h1000_0000, 32'h0000_0000}),
        .SlaveMask    ({32'hFFFF_FFF0, 32'hFFFF_0000}),
        .TimeoutCycles(T)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .wr_i           (wr_i),
        .strobe_i       (strobe_i),
        .rdata_o        (rdata_o),
        .ready_o        (ready_o),
        .err_o          (err_o),
        .s_sel_o        (s_sel_o),
        .s_addr_o       (s_addr_o),
        .s_wdata_o      (s_wdata_o),
        .s_wr_o         (s_wr_o),
        .s_rdata_i      (s_rdata_i),
        .s_ready_i      (s_ready_i),
        .err_count_o    (err_count_o),
        .last_err_addr_o(last_err_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_bad;
    int          m_err_count;
    logic [31:0] m_last_err;
    logic [31:0] win_base [2];
    logic [31:0] win_mask [2];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < 2; i++) begin
            if ((a & win_mask[i]) == win_base[i]) return i;
        end
        return -1;
    endfunction

    // lat: ACCESS cycle in which the target slave raises ready (0 = never).
    task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] wd, input int lat);
        int          idx;
        int          exp_cyc;
        int          got_cyc;
        logic        exp_err;
        logic        got_err;
        logic [31:0] got_rd;
        logic [31:0] exp_rd;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  exp_sel;
        logic [1:0]  noise;
        idx = ref_decode(a);
        d0  = $urandom;
        d1  = $urandom;
        if (idx < 0) begin
            exp_cyc = 2;
            exp_err = 1'b1;
        end else if (lat >= 1 && lat <= T) begin
            exp_cyc = lat + 1;
            exp_err = 1'b0;
        end else begin
            exp_cyc = T + 1;
            exp_err = 1'b1;
        end
        exp_sel = (idx < 0) ? 2'b00 : ((idx == 0) ? 2'b01 : 2'b10);
        exp_rd  = (exp_err || w) ? 32'h0 : ((idx == 0) ? d0 : d1);

        @(negedge clk);
        addr_i    = a;
        wdata_i   = wd;
        wr_i      = w;
        strobe_i  = 1'b1;
        s_rdata_i = {d1, d0};
        noise     = 2'($urandom);
        s_ready_i = noise & ~exp_sel;
        got_cyc   = 0;
        got_err   = 1'b0;
        got_rd    = 32'h0;
        for (int c = 1; c <= T + 6 && got_cyc == 0; c++) begin
            @(posedge clk);
            #1;
            strobe_i = 1'b0;
            addr_i   = $urandom;
            wdata_i  = $urandom;
            wr_i     = 1'($urandom);
            check_eq("sel", {30'h0, s_sel_o}, {30'h0, (c < exp_cyc) ? exp_sel : 2'b00});
            if (c == 1) begin
                check_eq("s_wr", {31'h0, s_wr_o}, {31'h0, (idx >= 0) ? w : 1'b0});
                check_eq("s_addr", s_addr_o, a);
                if (idx >= 0) check_eq("s_wdata", s_wdata_o, wd);
            end
            if (ready_o) begin
                got_cyc = c;
                got_err = err_o;
                got_rd  = rdata_o;
            end
            noise     = 2'($urandom);
            s_ready_i = (noise & ~exp_sel) | ((c == lat) ? exp_sel : 2'b00);
        end
        check_eq("ready_cycle", got_cyc, exp_cyc);
        if (got_cyc != 0) begin
            check_eq("err", {31'h0, got_err}, {31'h0, exp_err});
            check_eq("rdata", got_rd, exp_rd);
        end
        if (exp_err) begin
            if (m_err_count < 255) m_err_count++;
            m_last_err = a;
        end
        check_eq("err_count", {24'h0, err_count_o}, m_err_count);
        check_eq("last_err_addr", last_err_addr_o, m_last_err);
        @(posedge clk);
        #1;
        check_eq("ready_pulse", {31'h0, ready_o}, 32'h0);
        s_ready_i = 2'b00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          region;
        n_cmp       = 0;
        n_bad       = 0;
        m_err_count = 0;
        m_last_err  = 32'h0;
        win_base[0] = 32'h0000_0000;
        win_mask[0] = 32'hFFFF_0000;
        win_base[1] = 32'h1000_0000;
        win_mask[1] = 32'hFFFF_FFF0;
        rst_n     = 1'b0;
        addr_i    = 32'h0;
        wdata_i   = 32'h0;
        wr_i      = 1'b0;
        strobe_i  = 1'b0;
        s_rdata_i = 64'h0;
        s_ready_i = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", {31'h0, ready_o}, 32'h0);
        check_eq("rst_err", {31'h0, err_o}, 32'h0);
        check_eq("rst_sel", {30'h0, s_sel_o}, 32'h0);
        check_eq("rst_rdata", rdata_o, 32'h0);
        check_eq("rst_err_count", {24'h0, err_count_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(32'h0000_0040, 1'b0, 32'h0, 3);
        run_txn(32'h1000_0004, 1'b1, 32'h41, 1);
        run_txn(32'h2000_0000, 1'b0, 32'h0, 1);
        run_txn(32'h0000_1234, 1'b0, 32'h0, 0);
        run_txn(32'h1000_000F, 1'b0, 32'h0, T);
        run_txn(32'h1000_0010, 1'b0, 32'h0, 1);

        for (int n = 0; n < 40; n++) begin
            region = $urandom_range(0, 2);
            if (region == 0)      a = {16'h0000, 16'($urandom)};
            else if (region == 1) a = {28'h100_0000, 4'($urandom)};
            else                  a = $urandom;
            run_txn(a, 1'($urandom), $urandom, $urandom_range(1, T + 2));
        end

        // Second strobe while busy is ignored, then an async reset aborts the access.
        @(negedge clk);
        addr_i   = 32'h0000_0100;
        wr_i     = 1'b0;
        strobe_i = 1'b1;
        @(posedge clk);
        #1;
        strobe_i = 1'b0;
        check_eq("busy_sel", {30'h0, s_sel_o}, 32'h1);
        @(negedge clk);
        addr_i   = 32'h1000_0000;
        strobe_i = 1'b1;
        @(posedge clk);
        #1;
        strobe_i = 1'b0;
        check_eq("ignored_sel", {30'h0, s_sel_o}, 32'h1);
        check_eq("ignored_addr", s_addr_o, 32'h0000_0100);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_err_count = 0;
        m_last_err  = 32'h0;
        check_eq("abort_sel", {30'h0, s_sel_o}, 32'h0);
        check_eq("abort_addr", s_addr_o, 32'h0);
        check_eq("abort_ready", {31'h0, ready_o}, 32'h0);
        check_eq("abort_err_count", {24'h0, err_count_o}, 32'h0);
        check_eq("abort_last_err", last_err_addr_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_eq("abort_no_ready", {31'h0, ready_o}, 32'h0);
        end
        run_txn(32'h0000_0200, 1'b0, 32'h0, 2);

        for (int n = 0; n < 300; n++) begin
            run_txn({4'h2, 28'($urandom)}, 1'b0, 32'h0, 1);
        end
        check_eq("err_saturated", {24'h0, err_count_o}, 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
